// File: rtl/hbridge_deadtime_driver.sv
// H-bridge gate driver: decodes a two-pin direction request, soft-starts with a PWM
// duty ramp, enforces a dead interval on every exit from a driving state, honours end-stops.
module hbridge_deadtime_driver #(
  parameter int DEAD_CYCLES      = 50000,
  parameter int PWM_PERIOD       = 2500,
  parameter int RAMP_STEP_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic        req_b,
  input  logic [11:0] duty_max,
  input  logic        limit_fwd,
  input  logic        limit_rev,
  output logic        out_a,
  output logic        out_b,
  output logic [1:0]  state_o,
  output logic [11:0] duty_o,
  output logic        illegal_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN_FWD = 2'b01,
    RUN_REV = 2'b10,
    DEAD    = 2'b11
  } state_t;

  localparam logic [11:0] PERIOD_L  = 12'(PWM_PERIOD);
  localparam logic [11:0] PWM_LAST  = 12'(PWM_PERIOD - 1);
  localparam logic [11:0] RAMP_LAST = 12'(RAMP_STEP_CYCLES - 1);
  localparam logic [16:0] DEAD_LAST = 17'(DEAD_CYCLES);

  state_t      state;
  logic [11:0] pwm_cnt;
  logic [11:0] ramp_cnt;
  logic [11:0] duty_cur;
  logic [16:0] dead_cnt;
  logic        req_fwd;
  logic        req_rev;
  logic        pwm_on;
  logic [11:0] duty_tgt;

  // 11 decodes as neither direction, so it behaves like STOP
  assign req_fwd  = req_a & ~req_b;
  assign req_rev  = ~req_a & req_b;
  assign duty_tgt = (duty_max > PERIOD_L) ? PERIOD_L : duty_max;
  assign pwm_on   = (pwm_cnt < duty_cur);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pwm_cnt   <= '0;
      ramp_cnt  <= '0;
      duty_cur  <= '0;
      dead_cnt  <= '0;
      out_a     <= 1'b0;
      out_b     <= 1'b0;
      illegal_o <= 1'b0;
    end else begin
      // Gates follow the state held before this edge, so a state change shows one edge later
      out_a     <= (state == RUN_FWD) && pwm_on;
      out_b     <= (state == RUN_REV) && pwm_on;
      illegal_o <= illegal_o | (req_a & req_b);

      if (state == RUN_FWD || state == RUN_REV) begin
        pwm_cnt  <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
        ramp_cnt <= (ramp_cnt == RAMP_LAST) ? '0 : ramp_cnt + 1'b1;
        if (duty_cur > duty_tgt)
          duty_cur <= duty_tgt;
        else if (ramp_cnt == RAMP_LAST && duty_cur < duty_tgt)
          duty_cur <= duty_cur + 1'b1;
      end

      case (state)
        IDLE: begin
          if (req_fwd && !limit_fwd) begin
            state    <= RUN_FWD;
            pwm_cnt  <= '0;
            ramp_cnt <= '0;
            duty_cur <= '0;
          end else if (req_rev && !limit_rev) begin
            state    <= RUN_REV;
            pwm_cnt  <= '0;
            ramp_cnt <= '0;
            duty_cur <= '0;
          end
        end
        RUN_FWD: begin
          if (!req_fwd || limit_fwd) begin
            state    <= DEAD;
            dead_cnt <= '0;
          end
        end
        RUN_REV: begin
          if (!req_rev || limit_rev) begin
            state    <= DEAD;
            dead_cnt <= '0;
          end
        end
        DEAD: begin
          // Entry cycle plus DEAD_CYCLES counted cycles, requests ignored throughout
          if (dead_cnt == DEAD_LAST)
            state <= IDLE;
          else
            dead_cnt <= dead_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign state_o = state;
  assign duty_o  = duty_cur;

endmodule

// File: tb/tb_hbridge_deadtime_driver.sv
// Bench for hbridge_deadtime_driver: directed scenarios plus randomized request traffic,
// all checked every cycle against a timestamp-based reference model.
`timescale 1ns/1ps
module tb_hbridge_deadtime_driver;

  localparam int DC = 4;
  localparam int PP = 10;
  localparam int RS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a;
  logic        req_b;
  logic [11:0] duty_max;
  logic        limit_fwd;
  logic        limit_rev;
  logic        out_a;
  logic        out_b;
  logic [1:0]  state_o;
  logic [11:0] duty_o;
  logic        illegal_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: mode code, edge index of last RUN entry / RUN exit, duty, flags
  int m_mode  = 0;
  int m_entry = 0;
  int m_exit  = 0;
  int m_duty  = 0;
  bit m_ill   = 1'b0;
  bit m_oa    = 1'b0;
  bit m_ob    = 1'b0;

  hbridge_deadtime_driver #(
    .DEAD_CYCLES(DC),
    .PWM_PERIOD(PP),
    .RAMP_STEP_CYCLES(RS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_a(req_a),
    .req_b(req_b),
    .duty_max(duty_max),
    .limit_fwd(limit_fwd),
    .limit_rev(limit_rev),
    .out_a(out_a),
    .out_b(out_b),
    .state_o(state_o),
    .duty_o(duty_o),
    .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_step();
    int  tgt;
    int  ph;
    bit  fwd;
    bit  rev;
    if (rst) begin
      m_mode = 0; m_duty = 0; m_oa = 0; m_ob = 0; m_ill = 0;
      return;
    end
    tgt = (int'(duty_max) > PP) ? PP : int'(duty_max);
    ph  = cyc - 1 - m_entry;
    m_oa = (m_mode == 1) && ((ph % PP) < m_duty);
    m_ob = (m_mode == 2) && ((ph % PP) < m_duty);
    if (req_a && req_b) m_ill = 1;
    if (m_mode == 1 || m_mode == 2) begin
      if (tgt < m_duty) m_duty = tgt;
      else if ((ph % RS) == RS - 1 && m_duty < tgt) m_duty++;
    end
    fwd = req_a && !req_b;
    rev = !req_a && req_b;
    case (m_mode)
      0: begin
        if (fwd && !limit_fwd) begin m_mode = 1; m_entry = cyc; m_duty = 0; end
        else if (rev && !limit_rev) begin m_mode = 2; m_entry = cyc; m_duty = 0; end
      end
      1: if (!fwd || limit_fwd) begin m_mode = 3; m_exit = cyc; end
      2: if (!rev || limit_rev) begin m_mode = 3; m_exit = cyc; end
      default: if (cyc - m_exit == DC + 1) m_mode = 0;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    chk("state", 32'(state_o), 32'(m_mode));
    chk("out_a", 32'(out_a), 32'(m_oa));
    chk("out_b", 32'(out_b), 32'(m_ob));
    chk("duty", 32'(duty_o), 32'(m_duty));
    chk("illegal", 32'(illegal_o), 32'(m_ill));
    chk("overlap", 32'(out_a & out_b), 32'd0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int hi_a;
    int hi_b;
    int sel;
    int len;
    rst = 1'b1; req_a = 1'b1; req_b = 1'b0; duty_max = 12'd6;
    limit_fwd = 1'b0; limit_rev = 1'b0;

    // Reset with forward request held
    ticks(2);
    chk("rst_out_a", 32'(out_a), 32'd0);
    chk("rst_out_b", 32'(out_b), 32'd0);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_duty", 32'(duty_o), 32'd0);
    chk("rst_illegal", 32'(illegal_o), 32'd0);
    rst = 1'b0;
    tick();
    chk("release_state", 32'(state_o), 32'd1);
    ticks(11);
    chk("ramp_not_done", 32'(duty_o), 32'd5);
    tick();
    chk("ramp_done", 32'(duty_o), 32'd6);
    ticks(10);
    hi_a = 0; hi_b = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      hi_a += int'(out_a);
      hi_b += int'(out_b);
    end
    chk("fwd_high_count", 32'(hi_a), 32'd6);
    chk("fwd_out_b_count", 32'(hi_b), 32'd0);
    chk("hold_duty", 32'(duty_o), 32'd6);

    // Direction reversal: DEAD at E, IDLE at E+5, RUN_REV at E+6
    req_a = 1'b0; req_b = 1'b1;
    tick();
    chk("rev_dead_E", 32'(state_o), 32'd3);
    tick();
    chk("rev_out_a_E1", 32'(out_a), 32'd0);
    ticks(3);
    chk("rev_dead_E4", 32'(state_o), 32'd3);
    tick();
    chk("rev_idle_E5", 32'(state_o), 32'd0);
    tick();
    chk("rev_run_E6", 32'(state_o), 32'd2);
    chk("rev_duty_restart", 32'(duty_o), 32'd0);
    ticks(20);

    // Back to forward, then hit the forward end-stop
    req_a = 1'b1; req_b = 1'b0;
    ticks(7);
    chk("fwd_again", 32'(state_o), 32'd1);
    ticks(10);
    limit_fwd = 1'b1;
    tick();
    chk("limit_dead", 32'(state_o), 32'd3);
    ticks(5);
    chk("limit_idle", 32'(state_o), 32'd0);
    ticks(6);
    chk("limit_hold_idle", 32'(state_o), 32'd0);
    req_a = 1'b0; req_b = 1'b1;
    tick();
    chk("limit_rev_ok", 32'(state_o), 32'd2);
    ticks(5);

    // Illegal request during RUN_FWD
    req_a = 1'b1; req_b = 1'b0; limit_fwd = 1'b0;
    ticks(10);
    chk("ill_pre_run", 32'(state_o), 32'd1);
    req_b = 1'b1;
    tick();
    chk("ill_dead", 32'(state_o), 32'd3);
    chk("ill_flag", 32'(illegal_o), 32'd1);
    req_b = 1'b0;
    ticks(12);
    chk("ill_sticky", 32'(illegal_o), 32'd1);

    // Target drop and cap
    ticks(16);
    chk("tgt_pre", 32'(duty_o), 32'd6);
    duty_max = 12'd3;
    tick();
    chk("tgt_drop", 32'(duty_o), 32'd3);
    duty_max = 12'd4095;
    ticks(20);
    chk("tgt_cap", 32'(duty_o), 32'd10);
    hi_a = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      hi_a += int'(out_a);
    end
    chk("full_on", 32'(hi_a), 32'd10);

    // Reset mid-run drops outputs at that edge
    rst = 1'b1;
    tick();
    chk("midrst_out_a", 32'(out_a), 32'd0);
    chk("midrst_state", 32'(state_o), 32'd0);
    chk("midrst_illegal", 32'(illegal_o), 32'd0);
    rst = 1'b0;

    // Randomized traffic
    for (int seg = 0; seg < 200; seg++) begin
      sel = $urandom_range(0, 9);
      len = $urandom_range(1, 30);
      case (sel)
        0, 1, 2, 3: begin req_a = 1'b1; req_b = 1'b0; end
        4, 5, 6:    begin req_a = 1'b0; req_b = 1'b1; end
        7:          begin req_a = 1'b0; req_b = 1'b0; end
        default:    begin req_a = 1'b1; req_b = 1'b1; len = 1; end
      endcase
      limit_fwd = ($urandom_range(0, 7) == 0);
      limit_rev = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 5))
        0: duty_max = 12'd0;
        1: duty_max = 12'd3;
        2: duty_max = 12'd6;
        3: duty_max = 12'd10;
        4: duty_max = 12'd4095;
        default: duty_max = 12'($urandom_range(0, 4095));
      endcase
      rst = ($urandom_range(0, 39) == 0);
      if (rst) begin
        tick();
        rst = 1'b0;
      end
      ticks(len);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
